// File: rtl/ibex_alu_sched_if.sv
// Request/response bus between the ALU scheduler and its two clients.
// The scheduler takes the slave side; the clients (or a bench) take the master side.
interface ibex_alu_sched_if #(
  parameter int CntW = 3,
  parameter int OpW  = 7
);
  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][OpW-1:0]        req_operator;
  logic [1:0][31:0]           req_operand_a;
  logic [1:0][31:0]           req_operand_b;
  logic [1:0][CntW-1:0]       req_cycles;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [31:0]                rsp_result;
  logic                       rsp_cmp;

  modport master (
    output req_valid, req_operator, req_operand_a, req_operand_b, req_cycles, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_cmp
  );

  modport slave (
    input  req_valid, req_operator, req_operand_a, req_operand_b, req_cycles, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_cmp
  );
endinterface

// File: rtl/ibex_alu_sched.sv
// Round-robin scheduler sharing one ibex_alu between two requesters; sequences
// multi-cycle ops, owns the intermediate-value registers and returns a registered result.
module ibex_alu_sched #(
  parameter int CntW = 3,
  parameter int OpW  = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ibex_alu_sched_if.slave      bus,
  output logic                 busy,
  output logic [OpW-1:0]       alu_operator,
  output logic [31:0]          alu_operand_a,
  output logic [31:0]          alu_operand_b,
  output logic                 alu_instr_first_cycle,
  output logic [1:0][31:0]     alu_imd_val_q,
  input  logic [1:0][31:0]     alu_imd_val_d,
  input  logic [1:0]           alu_imd_val_we,
  input  logic [31:0]          alu_result,
  input  logic                 alu_comparison_result
);

  localparam logic [OpW-1:0] ALU_ADD = '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [CntW-1:0] OneCycle = {{(CntW-1){1'b0}}, 1'b1};

  logic [1:0]           state;
  logic                 rr;
  logic                 grant;
  logic [1:0]           ready;
  logic                 accept;
  logic                 last;

  logic [OpW-1:0]       op_q;
  logic [31:0]          a_q;
  logic [31:0]          b_q;
  logic                 id_q;
  logic [CntW-1:0]      n_q;
  logic [CntW-1:0]      cnt_q;
  logic [1:0][31:0]     imd_q;
  logic [31:0]          result_q;
  logic                 cmp_q;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = rr;
    if (bus.req_valid == 2'b01) begin
      grant = 1'b0;
    end else if (bus.req_valid == 2'b10) begin
      grant = 1'b1;
    end
    ready = 2'b00;
    if (state == IDLE) begin
      ready[grant] = bus.req_valid[grant];
    end
  end

  assign accept = |ready;
  assign last   = (cnt_q == n_q - OneCycle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr       <= 1'b0;
      op_q     <= ALU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      n_q      <= OneCycle;
      cnt_q    <= '0;
      imd_q    <= '0;
      result_q <= '0;
      cmp_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_q  <= bus.req_operator[grant];
            a_q   <= bus.req_operand_a[grant];
            b_q   <= bus.req_operand_b[grant];
            id_q  <= grant;
            n_q   <= (bus.req_cycles[grant] == '0) ? OneCycle : bus.req_cycles[grant];
            cnt_q <= '0;
            imd_q <= '0;
            rr    <= ~grant;
            state <= EXEC;
          end
        end
        EXEC: begin
          for (int k = 0; k < 2; k++) begin
            if (alu_imd_val_we[k]) begin
              imd_q[k] <= alu_imd_val_d[k];
            end
          end
          if (last) begin
            result_q <= alu_result;
            cmp_q    <= alu_comparison_result;
            state    <= RESP;
          end else begin
            cnt_q <= cnt_q + OneCycle;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The ALU only sees the latched op while executing; otherwise it idles on ADD 0,0.
  always_comb begin
    alu_operator          = ALU_ADD;
    alu_operand_a         = '0;
    alu_operand_b         = '0;
    alu_instr_first_cycle = 1'b0;
    if (state == EXEC) begin
      alu_operator          = op_q;
      alu_operand_a         = a_q;
      alu_operand_b         = b_q;
      alu_instr_first_cycle = (cnt_q == '0);
    end
  end

  assign alu_imd_val_q  = imd_q;
  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_cmp    = cmp_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_ibex_alu_sched.sv
// Bench for ibex_alu_sched: a small behavioural ALU drives the ALU side, and a
// reference model predicts grant order, latency and results for directed and random requests.
module tb_ibex_alu_sched;

  localparam int CntW = 3;
  localparam int OpW  = 7;

  localparam logic [OpW-1:0] OP_ADD  = 7'd0;
  localparam logic [OpW-1:0] OP_SUB  = 7'd1;
  localparam logic [OpW-1:0] OP_XOR  = 7'd2;
  localparam logic [OpW-1:0] OP_AND  = 7'd4;
  localparam logic [OpW-1:0] OP_EQ   = 7'd7;
  localparam logic [OpW-1:0] OP_CMIX = 7'd50;
  localparam logic [OpW-1:0] OP_MC   = 7'd51;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ibex_alu_sched_if #(.CntW(CntW), .OpW(OpW)) bus ();

  logic              busy;
  logic [OpW-1:0]    alu_operator;
  logic [31:0]       alu_operand_a;
  logic [31:0]       alu_operand_b;
  logic              alu_instr_first_cycle;
  logic [1:0][31:0]  alu_imd_val_q;
  logic [1:0][31:0]  alu_imd_val_d;
  logic [1:0]        alu_imd_val_we;
  logic [31:0]       alu_result;
  logic              alu_comparison_result;

  ibex_alu_sched #(.CntW(CntW), .OpW(OpW)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus                   (bus),
    .busy                  (busy),
    .alu_operator          (alu_operator),
    .alu_operand_a         (alu_operand_a),
    .alu_operand_b         (alu_operand_b),
    .alu_instr_first_cycle (alu_instr_first_cycle),
    .alu_imd_val_q         (alu_imd_val_q),
    .alu_imd_val_d         (alu_imd_val_d),
    .alu_imd_val_we        (alu_imd_val_we),
    .alu_result            (alu_result),
    .alu_comparison_result (alu_comparison_result)
  );

  // Stand-in ALU: MC chains through both imd registers so a lost write shows in the result.
  always_comb begin
    alu_result            = '0;
    alu_comparison_result = 1'b0;
    alu_imd_val_we        = 2'b00;
    alu_imd_val_d         = '0;
    case (alu_operator)
      OP_ADD: alu_result = alu_operand_a + alu_operand_b;
      OP_SUB: alu_result = alu_operand_a - alu_operand_b;
      OP_XOR: alu_result = alu_operand_a ^ alu_operand_b;
      OP_AND: alu_result = alu_operand_a & alu_operand_b;
      OP_EQ: begin
        alu_comparison_result = (alu_operand_a == alu_operand_b);
        alu_result            = {31'b0, alu_operand_a == alu_operand_b};
      end
      OP_CMIX: begin
        if (alu_instr_first_cycle) begin
          alu_imd_val_we   = 2'b01;
          alu_imd_val_d[0] = 32'hA5A5A5A5;
        end else begin
          alu_result = alu_imd_val_q[0] | alu_operand_a;
        end
      end
      OP_MC: begin
        if (alu_instr_first_cycle) begin
          alu_imd_val_we   = 2'b11;
          alu_imd_val_d[0] = alu_operand_a + alu_operand_b;
          alu_imd_val_d[1] = alu_operand_a ^ alu_operand_b;
          alu_result       = (alu_operand_a + alu_operand_b) ^ (alu_operand_a ^ alu_operand_b);
        end else begin
          alu_imd_val_we   = 2'b01;
          alu_imd_val_d[0] = alu_imd_val_q[0] + 32'd1;
          alu_result       = alu_imd_val_q[0] ^ alu_imd_val_q[1];
        end
      end
      default: ;
    endcase
  end

  int   vectors = 0;
  int   miscompares = 0;
  logic rr_model = 1'b0;

  logic [OpW-1:0]  t_op  [2];
  logic [31:0]     t_a   [2];
  logic [31:0]     t_b   [2];
  logic [CntW-1:0] t_cyc [2];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {cmp, result} from the operation's meaning and its cycle count.
  function automatic logic [32:0] refAlu(input logic [OpW-1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int n);
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_XOR:  r = a ^ b;
      OP_AND:  r = a & b;
      OP_EQ:   begin c = (a == b); r = {31'b0, c}; end
      OP_CMIX: r = 32'hA5A5A5A5 | a;
      OP_MC:   r = (a + b + 32'((n >= 2) ? n - 2 : 0)) ^ (a ^ b);
      default: r = '0;
    endcase
    return {c, r};
  endfunction

  task automatic applyStimulus(input logic [1:0] v, input int stall);
    int          g;
    int          n;
    int          k;
    logic [32:0] e;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      bus.req_operator[i]  = t_op[i];
      bus.req_operand_a[i] = t_a[i];
      bus.req_operand_b[i] = t_b[i];
      bus.req_cycles[i]    = t_cyc[i];
    end
    bus.req_valid = v;
    bus.rsp_ready = 1'b0;
    #1;
    g = (v == 2'b11) ? int'(rr_model) : (v[1] ? 1 : 0);
    checkOutput("req_ready", 32'(bus.req_ready), (g == 1) ? 32'd2 : 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    n = (t_cyc[g] == '0) ? 1 : int'(t_cyc[g]);
    e = refAlu(t_op[g], t_a[g], t_b[g], n);
    rr_model = (g == 0);
    @(posedge clk); #1;
    k = 0;
    while (!bus.rsp_valid && k < 40) begin
      checkOutput("first_cycle", 32'(alu_instr_first_cycle), 32'(k == 0));
      checkOutput("busy_exec", 32'(busy), 32'd1);
      checkOutput("ready_exec", 32'(bus.req_ready), 32'd0);
      checkOutput("alu_op", 32'(alu_operator), 32'(t_op[g]));
      if (t_op[g] == OP_CMIX && k == 1)
        checkOutput("imd_q0", alu_imd_val_q[0], 32'hA5A5A5A5);
      @(posedge clk); #1;
      k++;
    end
    checkOutput("latency", 32'(k), 32'(n));
    for (int s = 0; s <= stall; s++) begin
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("rsp_id", 32'(bus.rsp_id), 32'(g));
      checkOutput("rsp_result", bus.rsp_result, e[31:0]);
      checkOutput("rsp_cmp", 32'(bus.rsp_cmp), 32'(e[32]));
      checkOutput("ready_resp", 32'(bus.req_ready), 32'd0);
      checkOutput("alu_op_resp", 32'(alu_operator), 32'(OP_ADD));
      if (s < stall) begin
        @(posedge clk); #1;
      end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b00;
    #1;
    checkOutput("rsp_done", 32'(bus.rsp_valid), 32'd0);
    checkOutput("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic setReq(input int i, input logic [OpW-1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [CntW-1:0] cyc);
    t_op[i]  = op;
    t_a[i]   = a;
    t_b[i]   = b;
    t_cyc[i] = cyc;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    checkOutput("rst_rsp_cmp", 32'(bus.rsp_cmp), 32'd0);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_operator), 32'(OP_ADD));
    checkOutput("rst_operand_a", alu_operand_a, 32'd0);
    checkOutput("rst_operand_b", alu_operand_b, 32'd0);
    checkOutput("rst_first", 32'(alu_instr_first_cycle), 32'd0);
    checkOutput("rst_imd0", alu_imd_val_q[0], 32'd0);
    checkOutput("rst_imd1", alu_imd_val_q[1], 32'd0);
  endtask

  logic [OpW-1:0] ops [6] = '{OP_ADD, OP_SUB, OP_XOR, OP_AND, OP_EQ, OP_MC};

  initial begin
    logic first;
    logic seen;
    logic [1:0] v;
    bus.req_valid     = 2'b00;
    bus.req_operator  = '0;
    bus.req_operand_a = '0;
    bus.req_operand_b = '0;
    bus.req_cycles    = '0;
    bus.rsp_ready     = 1'b0;
    for (int i = 0; i < 2; i++) setReq(i, OP_ADD, 32'd0, 32'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;

    setReq(0, OP_ADD, 32'd10, 32'd5, 3'd1);
    applyStimulus(2'b01, 0);

    for (int rep = 0; rep < 2; rep++) begin
      setReq(0, OP_SUB, 32'd20, 32'd8, 3'd1);
      setReq(1, OP_AND, 32'hFFFF0000, 32'h0000FFFF, 3'd1);
      first = rr_model;
      applyStimulus(2'b11, 0);
      applyStimulus(first ? 2'b01 : 2'b10, 0);
    end

    setReq(1, OP_CMIX, 32'd0, 32'd0, 3'd2);
    applyStimulus(2'b10, 0);

    setReq(0, OP_EQ, 32'd100, 32'd100, 3'd1);
    applyStimulus(2'b01, 3);
    setReq(0, OP_EQ, 32'd100, 32'd99, 3'd1);
    applyStimulus(2'b01, 0);

    setReq(0, OP_MC, 32'h1234, 32'h0F0F, 3'd0);
    applyStimulus(2'b01, 0);
    setReq(1, OP_MC, 32'hDEAD0000, 32'h0000BEEF, 3'd7);
    applyStimulus(2'b10, 1);

    // Reset in the third EXEC cycle of a 7-cycle op: the op must vanish without a response.
    setReq(0, OP_MC, 32'h00C0FFEE, 32'h11111111, 3'd7);
    @(posedge clk); #1;
    bus.req_operator[0]  = t_op[0];
    bus.req_operand_a[0] = t_a[0];
    bus.req_operand_b[0] = t_b[0];
    bus.req_cycles[0]    = t_cyc[0];
    bus.req_valid        = 2'b01;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    rr_model = 1'b0;
    #1;
    checkResetOutputs();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | bus.rsp_valid;
    end
    checkOutput("no_rsp_after_reset", 32'(seen), 32'd0);
    setReq(0, OP_ADD, 32'd1, 32'd1, 3'd1);
    applyStimulus(2'b01, 0);

    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 2; i++)
        setReq(i, ops[$urandom_range(0, 5)], $urandom, $urandom, CntW'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) t_b[0] = t_a[0];
      v = 2'($urandom_range(1, 3));
      applyStimulus(v, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
